// File: rtl/aes_decipher_block.sv
// Iterative AES-128/256 inverse cipher: one InvSubWord per cycle through a shared
// inverse S-box, round keys fetched from an external key memory by descending index.

module aes_inv_sbox (
    input  logic [31:0] sword,
    output logic [31:0] new_sword
);
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] b);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = b;
        acc = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] inv_sub(input logic [7:0] b);
        logic [7:0] a;
        a = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        return gf_inv(a);
    endfunction

    assign new_sword = {inv_sub(sword[31:24]), inv_sub(sword[23:16]),
                        inv_sub(sword[15:8]),  inv_sub(sword[7:0])};
endmodule

// state | meaning
// IDLE  | result valid, waiting for next
// SBOX  | InvSubWord on one state word per cycle
// MAIN  | AddRoundKey, InvMixColumns, InvShiftRows for rounds Nr-1..1
// FINAL | last AddRoundKey with round key 0
module aes_decipher_block (
    input  logic         clk,
    input  logic         reset,
    input  logic         keylen,
    input  logic         next,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    input  logic [127:0] block,
    output logic [127:0] new_block,
    output logic         ready
);
    typedef enum logic [1:0] {IDLE, SBOX, MAIN, FINAL} state_t;

    state_t       state_q, state_d;
    logic [127:0] block_q, block_d;
    logic [3:0]   round_ctr, round_d;
    logic [1:0]   word_ctr, word_d;
    logic         keylen_q, keylen_d;
    logic         ready_q, ready_d;
    logic [31:0]  sbox_in, sbox_out;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_word(input logic [31:0] w);
        logic [7:0] a [4];
        logic [7:0] m09 [4];
        logic [7:0] m0b [4];
        logic [7:0] m0d [4];
        logic [7:0] m0e [4];
        logic [7:0] x1, x2, x3;
        for (int i = 0; i < 4; i++) begin
            a[i]   = w[31-8*i -: 8];
            x1     = xtime(a[i]);
            x2     = xtime(x1);
            x3     = xtime(x2);
            m09[i] = x3 ^ a[i];
            m0b[i] = x3 ^ x1 ^ a[i];
            m0d[i] = x3 ^ x2 ^ a[i];
            m0e[i] = x3 ^ x2 ^ x1;
        end
        return {m0e[0] ^ m0b[1] ^ m0d[2] ^ m09[3],
                m09[0] ^ m0e[1] ^ m0b[2] ^ m0d[3],
                m0d[0] ^ m09[1] ^ m0e[2] ^ m0b[3],
                m0b[0] ^ m0d[1] ^ m09[2] ^ m0e[3]};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        return {inv_mix_word(s[127:96]), inv_mix_word(s[95:64]),
                inv_mix_word(s[63:32]),  inv_mix_word(s[31:0])};
    endfunction

    // row r of each column is rotated right by r columns
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        return {s[127:120], s[23:16],   s[47:40],  s[71:64],
                s[95:88],   s[119:112], s[15:8],   s[39:32],
                s[63:56],   s[87:80],   s[111:104], s[7:0],
                s[31:24],   s[55:48],   s[79:72],  s[103:96]};
    endfunction

    assign sbox_in = block_q[{~word_ctr, 5'b0} +: 32];

    aes_inv_sbox u_inv_sbox (
        .sword     (sbox_in),
        .new_sword (sbox_out)
    );

    always_comb begin
        state_d  = state_q;
        block_d  = block_q;
        round_d  = round_ctr;
        word_d   = word_ctr;
        keylen_d = keylen_q;
        ready_d  = ready_q;
        case (state_q)
            IDLE: begin
                if (next) begin
                    block_d  = inv_shift_rows(block ^ round_key);
                    keylen_d = keylen;
                    round_d  = keylen ? 4'd13 : 4'd9;
                    word_d   = 2'd0;
                    ready_d  = 1'b0;
                    state_d  = SBOX;
                end
            end
            SBOX: begin
                block_d[{~word_ctr, 5'b0} +: 32] = sbox_out;
                word_d = word_ctr + 2'd1;
                if (word_ctr == 2'd3) state_d = (round_ctr != 4'd0) ? MAIN : FINAL;
            end
            MAIN: begin
                block_d = inv_shift_rows(inv_mix_columns(block_q ^ round_key));
                round_d = round_ctr - 4'd1;
                state_d = SBOX;
            end
            FINAL: begin
                block_d = block_q ^ round_key;
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            block_q   <= '0;
            round_ctr <= '0;
            word_ctr  <= '0;
            keylen_q  <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            block_q   <= block_d;
            round_ctr <= round_d;
            word_ctr  <= word_d;
            keylen_q  <= keylen_d;
            ready_q   <= ready_d;
        end
    end

    // the round counter alone sequences the operation; the latched key length is kept as state only
    logic unused_keylen;
    assign unused_keylen = keylen_q;

    assign round     = (state_q == IDLE) ? (keylen ? 4'd14 : 4'd10) : round_ctr;
    assign new_block = block_q;
    assign ready     = ready_q;
endmodule

// File: tb/tb_aes_decipher_block.sv
// Scoreboard bench: plaintexts are encrypted by a forward AES model, the DUT decrypts,
// and a monitor checks results, latency and the round-index sequence.
module tb_aes_decipher_block;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         keylen = 1'b0;
    logic         next = 1'b0;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic [127:0] block = '0;
    logic [127:0] new_block;
    logic         ready;

    logic [127:0] rk_mem [16];
    logic [127:0] rks [16];
    logic [7:0]   sb [256];

    typedef struct {
        logic [127:0] pt;
        int           lat;
    } exp_t;
    exp_t exp_q [$];

    int n_vec = 0;
    int n_err = 0;

    localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT_STD = 128'h00112233445566778899aabbccddeeff;

    aes_decipher_block dut (
        .clk       (clk),
        .reset     (reset),
        .keylen    (keylen),
        .next      (next),
        .round     (round),
        .round_key (round_key),
        .block     (block),
        .new_block (new_block),
        .ready     (ready)
    );

    always #5 clk = ~clk;
    assign round_key = rk_mem[round];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // forward S-box: brute-force field inverse followed by the affine map
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    task automatic expand(input logic [255:0] key, input logic klen);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int nk, nr;
        nk = klen ? 8 : 4;
        nr = klen ? 14 : 10;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk == 8 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input int nr);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rks[0][127-8*i -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++) t[4*c+rr] = s[4*((c+rr)%4)+rr];
            s = t;
            if (r != nr) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gm(8'h02, a0) ^ gm(8'h03, a1) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gm(8'h02, a1) ^ gm(8'h03, a2) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gm(8'h02, a2) ^ gm(8'h03, a3);
                    s[4*c+3] = gm(8'h03, a0) ^ a1 ^ a2 ^ gm(8'h02, a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rks[r][127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    task automatic start_op(input logic [255:0] key, input logic klen,
                            input logic [127:0] ct, input logic [127:0] pt);
        exp_t e;
        expand(key, klen);
        for (int r = 0; r < 16; r++) rk_mem[r] = rks[r];
        keylen = klen;
        block  = ct;
        next   = 1'b1;
        e.pt   = pt;
        e.lat  = klen ? 70 : 50;
        exp_q.push_back(e);
        @(posedge clk); #1;
        next = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!ready && n < 200);
        if (!ready) check("done_timeout", 128'(ready), 128'd1);
    endtask

    task automatic random_op(input logic force_len, input logic len_val);
        logic [255:0] key;
        logic [127:0] pt;
        logic klen;
        key  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        pt   = {$urandom, $urandom, $urandom, $urandom};
        klen = force_len ? len_val : 1'($urandom_range(0, 1));
        expand(key, klen);
        start_op(key, klen, encrypt(pt, klen ? 14 : 10), pt);
    endtask

    // monitor: result and latency on each ready rise, round index every cycle
    logic prev_ready = 1'b1;
    int   busy = 0;
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy = 0;
                prev_ready = 1'b1;
            end else begin
                if (ready) begin
                    if (!prev_ready) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_done", 128'd1, 128'd0);
                        end else begin
                            e = exp_q.pop_front();
                            check("plaintext", new_block, e.pt);
                            check("latency", 128'(busy), 128'(e.lat));
                        end
                        busy = 0;
                    end
                    check("round_idle", 128'(round), keylen ? 128'd14 : 128'd10);
                end else begin
                    if (exp_q.size() == 0)
                        check("busy_without_op", 128'd1, 128'd0);
                    else
                        check("round_busy", 128'(round), 128'(exp_q[0].lat / 5 - 1 - busy / 5));
                    busy++;
                end
                prev_ready = ready;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        for (int r = 0; r < 16; r++) rk_mem[r] = '0;
        build_sbox();
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 128'(ready), 128'd1);
        check("reset_block", new_block, 128'h0);
        check("reset_round128", 128'(round), 128'd10);
        keylen = 1'b1;
        #1;
        check("reset_round256", 128'(round), 128'd14);
        keylen = 1'b0;
        reset  = 1'b0;
        @(posedge clk); #1;

        start_op(KEY_C1, 1'b0, CT_C1, PT_STD);
        wait_done();
        start_op(KEY_C3, 1'b1, CT_C3, PT_STD);
        wait_done();

        // busy-time next, keylen and block must not disturb the running operation
        start_op(KEY_C1, 1'b0, CT_C1, PT_STD);
        repeat (19) begin @(posedge clk); #1; end
        next   = 1'b1;
        keylen = 1'b1;
        block  = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        next   = 1'b0;
        keylen = 1'b0;
        wait_done();

        // reset mid-operation abandons the result
        start_op(KEY_C1, 1'b0, CT_C1, PT_STD);
        repeat (29) begin @(posedge clk); #1; end
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        check("abort_ready", 128'(ready), 128'd1);
        check("abort_block", new_block, 128'h0);
        reset = 1'b0;
        @(posedge clk); #1;
        start_op(KEY_C1, 1'b0, CT_C1, PT_STD);
        wait_done();

        // back-to-back: second start in the first ready cycle
        start_op(KEY_C1, 1'b0, CT_C1, PT_STD);
        wait_done();
        random_op(1'b1, 1'b1);
        check("b2b_busy_again", 128'(ready), 128'd0);
        wait_done();
        random_op(1'b1, 1'b0);
        check("b2b_busy_again2", 128'(ready), 128'd0);
        wait_done();

        for (int k = 0; k < 8; k++) begin
            random_op(1'b0, 1'b0);
            wait_done();
        end

        repeat (3) begin @(posedge clk); #1; end
        check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/aes_decipher_block.md
Name: aes_decipher_block

Overview:
- Iterative AES-128/AES-256 inverse cipher; the decryption counterpart of the encipher block inside the AES core.
- Takes a 128-bit ciphertext block and produces the plaintext.
- Reads pre-expanded round keys from the key memory by round index, walking downwards from Nr to 0.
- Uses one shared 32-bit inverse S-box (aes_inv_sbox), so it processes one word per cycle during InvSubBytes.

Parameters:
- None. Round counts are fixed: AES-128 Nr=10, AES-256 Nr=14.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- keylen  in  1  0 = AES-128, 1 = AES-256. Latched when next is accepted.
- next  in  1  start pulse. Accepted only in IDLE.
- round  out  4  round-key index presented to the key memory.
- round_key  in  128  key memory data for index round, valid combinationally in the same cycle.
- block  in  128  ciphertext. Sampled only in the cycle next is accepted.
- new_block  out  128  internal state register; holds the plaintext when ready=1 after an operation.
- ready  out  1  1 = idle and result valid; 0 = busy.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE; ready=1; new_block=128'h0; round counter=0; word counter=0; latched keylen=0.
  - Reset has priority over everything, including mid-operation. An in-flight operation is abandoned with no partial result preserved.
- round output:
  - In IDLE, round = (keylen ? 14 : 10), driven combinationally from the live keylen input.
  - Otherwise round = round counter.
- Byte/word layout: word0 = bits [127:96]; byte0 of a word = its MSB byte. This matches the encipher column ordering.
- FSM states: IDLE, SBOX, MAIN, FINAL.
- IDLE, next=1 (one cycle):
  - state <= InvShiftRows(block ^ round_key), with round_key for index Nr.
  - Latch keylen; round counter <= Nr-1; word counter <= 0; ready <= 0; go to SBOX.
- IDLE, next=0: hold all state; ready stays 1.
- SBOX (4 cycles):
  - Each cycle, state word[word counter] <= InvSubWord(state word[word counter]).
  - word counter increments 0→3 and wraps to 0 on exit.
  - After word 3: go to MAIN if round counter > 0, else go to FINAL.
- MAIN (1 cycle):
  - state <= InvShiftRows(InvMixColumns(state ^ round_key)).
  - round counter decrements; go to SBOX.
- FINAL (1 cycle):
  - state <= state ^ round_key (round 0).
  - ready <= 1; go to IDLE.
- InvMixColumns per column uses coefficients {0e,0b,0d,09} in GF(2^8) with polynomial 0x11b.
- Latency: ready is low for exactly 5·Nr cycles (50 for AES-128, 70 for AES-256). Plaintext is valid on new_block in the first cycle ready=1.
- Round index sequence: Nr, then Nr-1 … 1 (each held for 5 cycles: 4 SBOX + 1 MAIN), then 0 (held for 5 cycles: 4 SBOX + 1 FINAL).
- Busy-time inputs: next while busy is ignored, with no queuing; keylen and block changes while busy have no effect.
- Back-to-back: next asserted in the same cycle ready returns to 1 is accepted, and a new operation starts.
- new_block holds its value in IDLE until the next accepted start.
- Reset during the IDLE→SBOX transition cycle: reset wins, and the block ends in IDLE with ready=1.

Test Plan:
- AES-128 (FIPS-197 C.1): key memory loaded with the expansion of key 000102030405060708090a0b0c0d0e0f; block=69c4e0d86a7b0430d8cdb78070b4c55a, keylen=0, pulse next → ready low for 50 cycles; new_block=00112233445566778899aabbccddeeff.
- AES-256 (FIPS-197 C.3): key 000102…1e1f, block=8ea2b7ca516745bfeafc49904b496089, keylen=1 → ready low for 70 cycles; new_block=00112233445566778899aabbccddeeff.
- Round sequence: monitor round during the AES-128 run → 10, then 9…0, each index other than the first held for 5 cycles; the cycle after ready rises, round=10 again.
- Busy robustness: pulse next and toggle keylen/block at cycle 20 of an AES-128 run → result is unchanged, and ready still rises at cycle 50.
- Reset mid-operation: assert reset at cycle 30 → next cycle ready=1, new_block=0. A fresh C.1 run afterwards gives the correct plaintext.
- Back-to-back: second next in the first ready=1 cycle, with a new ciphertext → both results are correct; there is exactly one idle cycle between the two busy windows.
